// File: rtl/sa_pkg.sv
// Shared definitions for the shift-and-add multiplier: state encoding,
// counter width and default operand width.
package sa_pkg;
  localparam int CNT_W     = 4;
  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_t;
endpackage

// File: rtl/bit_down_counter.sv
// Step counter for the multiply sequence: loads the operand width, counts
// down one per multiplier bit and flags the final step.
module bit_down_counter
  import sa_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_value,
  input  logic             decr,
  output logic             is_one
);

  logic [CNT_W-1:0] count;

  // Load takes priority so a stray decrement can never corrupt a fresh count.
  always_ff @(posedge clk) begin
    if (rst)       count <= '0;
    else if (ld)   count <= ld_value;
    else if (decr) count <= count - 1'b1;
  end

  assign is_one = (count == CNT_W'(1));

endmodule

// File: rtl/shift_add_multiplier.sv
// Unsigned sequential shift-and-add multiplier feeding the PE accumulator.
// One multiplier bit per cycle; the product is held until the next accepted start.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   ST_IDLE | waiting for start; operands captured when it arrives
//   ST_RUN  | one add/shift step per cycle, WIDTH steps in total
//   ST_DONE | product just registered, done pulse high for one cycle
module shift_add_multiplier
  import sa_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc;
  logic [WIDTH:0]   sum;
  logic             cnt_ld;
  logic             cnt_decr;
  logic             last_step;

  assign cnt_ld   = (state == ST_IDLE) && start;
  assign cnt_decr = (state == ST_RUN);

  bit_down_counter u_cnt (
    .clk      (clk),
    .rst      (rst),
    .ld       (cnt_ld),
    .ld_value (CNT_W'(WIDTH)),
    .decr     (cnt_decr),
    .is_one   (last_step)
  );

  // Carry is kept in sum[WIDTH] and shifts down into acc on the same step.
  assign sum = {1'b0, acc} + (b_reg[0] ? {1'b0, a_reg} : {(WIDTH+1){1'b0}});

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= a_in;
            b_reg <= b_in;
            acc   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          {acc, b_reg} <= {sum, b_reg[WIDTH-1:1]};
          if (last_step) begin
            product <= {sum, b_reg[WIDTH-1:1]};
            done    <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Unsigned sequential shift-and-add multiplier for the systolic-array processing element. It sits directly upstream of the PE accumulator and owns the bit-serial multiply sequence. It loads and decrements a 4-bit down-counter with one step per multiplier bit, and produces a full-width product with a single-cycle `done` pulse. Operand capture uses a start handshake; the result is held stable until the next accepted start.

## Interface
Parameters:
- `WIDTH`, default 8: operand width in bits. Legal range is 2..15, bounded by the 4-bit counter.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request to multiply. Sampled only in IDLE.
- `a_in`, input, WIDTH: multiplicand. Captured on the accepted start.
- `b_in`, input, WIDTH: multiplier. Captured on the accepted start.
- `busy`, output, 1: high in RUN and DONE.
- `done`, output, 1: one-cycle pulse, high exactly in DONE.
- `product`, output, 2*WIDTH: result. Holds its value until the next accepted start.

## Operation
- Reset, with `rst` high at an edge:
  - state becomes IDLE;
  - `busy`, `done` and `product` go to 0;
  - internal A, acc and B go to 0;
  - the count goes to 0.
- IDLE:
  - On `start`=1: A<=`a_in`, B<=`b_in`, acc<=0, count<=WIDTH (counter Ld), then go to RUN.
  - Otherwise stay in IDLE.
- RUN, one step per cycle:
  - sum = {1'b0,acc} + (B[0] ? {1'b0,A} : 0). This is WIDTH+1 bits and the carry is kept.
  - {acc,B} <= {sum,B[WIDTH-1:1]}, i.e. a right shift of the (WIDTH+1)+WIDTH concatenation that drops B[0].
  - count decrements (counter decr).
  - When count==1 on this step, go to DONE.
- DONE:
  - `product` <= {acc,B}, registered on entry; `done`=1.
  - Return to IDLE next cycle unconditionally.
- `start` outside IDLE is ignored: no capture and no effect on the sequence in flight.
- Counter Ld and decr are never both asserted. Ld has priority if they ever are.
- Arithmetic is unsigned and never overflows: the maximum product is (2^WIDTH-1)^2, which is less than 2^(2*WIDTH).
- `product` is written only on entry to DONE, and does not change in IDLE, RUN or DONE afterwards. It is cleared only by `rst`.

## Timing
- With `start` accepted at edge k:
  - RUN occupies cycles k+1..k+WIDTH;
  - DONE, `done`=1 and the new `product` are visible in cycle k+WIDTH+1;
  - the block is back in IDLE at k+WIDTH+2.
- Total latency from start to done is WIDTH+1 cycles. The minimum start-to-start interval is WIDTH+2 cycles.
- `busy` rises the cycle after acceptance and falls together with `done`.
- `rst` mid-RUN or in DONE aborts at that edge: there is no `done` pulse and `product` is cleared to 0.
- If `rst` and `start` are high on the same edge, reset wins and the start is dropped.

## Structure
- Shared package `sa_pkg`:
  - state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - `CNT_W`=4;
  - the default operand width.
- One sub-module, `bit_down_counter`:
  - a 4-bit register with `ld`, `ld_value`, `decr` and a zero/one flag output;
  - it gains `rst` (synchronous, clears to 0).
- Top level: FSM plus datapath (A, acc, B registers and a WIDTH+1 adder).

## Test plan
- Nominal case: `a_in`=13, `b_in`=11, `start` pulse. Required: `product`=143 with `done` high exactly 9 cycles after the start edge, and `busy` high for cycles 1..9.
- Extremes:
  - 255×255 gives `product`=65025 (carry path);
  - 0×200 gives 0;
  - 1×255 gives 255.
- Start while busy: a second `start` with `a_in`=7, `b_in`=7 at cycle 3 of a 13×11 run. Required: the result is still 143, a single `done` pulse occurs, and the block returns to IDLE at cycle 10.
- Reset mid-operation: `rst` at cycle 5 of a 200×3 run. Required: the next cycle shows IDLE with `busy`=0 and `product`=0, no `done` pulse follows, and a subsequent 6×7 run returns 42.
- Back-to-back runs: start 2×3, then start 9×9 in the first IDLE cycle after `done`. Required: products 6 then 81, with `product` holding 6 until the second `done`.
- Parameter sweep: WIDTH=4 and WIDTH=15, each with a 1000-vector random run checked against a reference model. Required latency is 5 and 16 cycles respectively.
